// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, fetch-queue state encoding and word width.
// The predecode helper is only used when IFQ_PREDECODE_EN is defined.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] FN_JR    = 6'd8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifq_state_t;

  // True for control-transfer instructions: j, jal, beq, bne and jr.
  function automatic logic is_cti(input logic [WORD_W-1:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
           ((op == OP_RTYPE) && (fn == FN_JR));
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with clear, used for both the instruction queue
// and the tag queue of issued fetch addresses. DEPTH must be a power of 2.
// A push while full is accepted when a pop happens in the same cycle.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; written on accepted pushes, never reset (contents are qualified by count).
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; reset and clear both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch stage: issues sequential word fetches under a
// credit limit, queues returned words with their PC and hands them to decode
// over valid/ready. A redirect flushes the queue and drops stale responses.
// Optional feature macro: IFQ_PREDECODE_EN adds the per-entry ir_is_cti flag.
module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [WORD_W-1:0] ir_data,
  output logic [WORD_W-1:0] ir_pc,
`ifdef IFQ_PREDECODE_EN
  output logic [WORD_W-1:0] ir_pc4,
  output logic              ir_is_cti
`else
  output logic [WORD_W-1:0] ir_pc4
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFQ_PREDECODE_EN
  localparam int DW = 2 * WORD_W + 1;
`else
  localparam int DW = 2 * WORD_W;
`endif

  ifq_state_t        state;
  logic [WORD_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     drop_after_redirect;

  logic              rvalid_eff;
  logic              grant;
  logic [CW:0]       occupancy;

  logic              data_push;
  logic              data_pop;
  logic [DW-1:0]     data_wdata;
  logic [DW-1:0]     data_head;
  logic [CW-1:0]     data_count;
  logic              data_full;
  logic              data_empty;

  logic [WORD_W-1:0] tag_head;
  logic [CW-1:0]     tag_count;
  logic              tag_full;
  logic              tag_empty;

  logic              out_en;
  logic              ifq_unused;

  // Handshake qualification, credit check and fetch request generation.
  always_comb begin
    rvalid_eff          = imem_rvalid && (outstanding != '0);
    occupancy           = (CW+1)'(data_count) + (CW+1)'(outstanding);
    imem_req            = rst_n && (state == RUN) && !redirect_valid &&
                          (occupancy < (CW+1)'(DEPTH));
    imem_addr           = fetch_pc;
    grant               = imem_req && imem_gnt;
    drop_after_redirect = outstanding - CW'(rvalid_eff);
    data_push           = rvalid_eff && (state == RUN) && !redirect_valid;
    data_pop            = ir_valid && ir_ready;
  end

`ifdef IFQ_PREDECODE_EN
  assign data_wdata = {is_cti(imem_rdata), imem_rdata, tag_head};
`else
  assign data_wdata = {imem_rdata, tag_head};
`endif

  ifq_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .pop   (data_push),
    .clear (redirect_valid),
    .wdata (fetch_pc),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  ifq_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_push),
    .pop   (data_pop),
    .clear (redirect_valid),
    .wdata (data_wdata),
    .rdata (data_head),
    .count (data_count),
    .full  (data_full),
    .empty (data_empty)
  );

  // Decode-side outputs come straight from queue storage and read as zero when empty or in reset.
  always_comb begin
    out_en   = rst_n && !data_empty;
    ir_valid = out_en;
    ir_pc    = out_en ? data_head[WORD_W-1:0] : '0;
    ir_data  = out_en ? data_head[2*WORD_W-1:WORD_W] : '0;
    ir_pc4   = out_en ? (data_head[WORD_W-1:0] + 32'd4) : '0;
  end

`ifdef IFQ_PREDECODE_EN
  assign ir_is_cti = out_en && data_head[DW-1];
`endif

  // Fetch PC, credit counter and RUN/FLUSH control; a redirect overrides everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rvalid_eff);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= drop_after_redirect;
        state    <= (drop_after_redirect != '0) ? FLUSH : RUN;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if ((state == FLUSH) && rvalid_eff) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) begin
            state <= RUN;
          end
        end
      end
    end
  end

  assign ifq_unused = &{1'b0, tag_count, tag_full, tag_empty, data_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a table of per-cycle vectors plus
// hand-written redirect and reset-PC-wrap sequences. A second instance with
// RESET_PC=32'hFFFFFFFC runs alongside on a fixed 1-cycle memory.
// Feature macro IFQ_PREDECODE_EN enables the ir_is_cti checks.
`timescale 1ns/1ps
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc4;
  logic        ir_is_cti;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        valid2;
  logic [31:0] data2;
  logic [31:0] pc2;
  logic [31:0] pc4_2;
  logic        cti2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       resp_q[$];
  logic        pend2;
  logic [31:0] pend2_addr;

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_cti;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Cycle index of the next rising edge, used to time memory responses.
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
`ifdef IFQ_PREDECODE_EN
    .ir_pc4         (ir_pc4),
    .ir_is_cti      (ir_is_cti)
`else
    .ir_pc4         (ir_pc4)
`endif
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_gnt       (1'b1),
    .imem_rvalid    (rvalid2),
    .imem_rdata     (rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .ir_valid       (valid2),
    .ir_ready       (1'b1),
    .ir_data        (data2),
    .ir_pc          (pc2),
`ifdef IFQ_PREDECODE_EN
    .ir_pc4         (pc4_2),
    .ir_is_cti      (cti2)
`else
    .ir_pc4         (pc4_2)
`endif
  );

  // Instruction memory contents: j, jr, nop at 0/4/8, addi-style words elsewhere.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h08000010;
      32'h4:   return 32'h03E00008;
      32'h8:   return 32'h00000000;
      default: return 32'h21080000 ^ a;
    endcase
  endfunction

  function automatic vec_t mkv(input logic r, input logic g, input logic rd,
                               input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep, input logic ec);
    vec_t v;
    v.rst_n = r;  v.gnt = g;  v.ready = rd;  v.redir = 1'b0;  v.redir_pc = 32'h0;
    v.exp_req = eq;  v.exp_addr = ea;  v.exp_valid = ev;  v.exp_pc = ep;  v.exp_cti = ec;
    return v;
  endfunction

  function automatic vec_t withRedirect(input vec_t v, input logic [31:0] pc);
    vec_t r;
    r = v;
    r.redir = 1'b1;
    r.redir_pc = pc;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n          = v.rst_n;
    imem_gnt       = v.gnt;
    ir_ready       = v.ready;
    redirect_valid = v.redir;
    redirect_pc    = v.redir_pc;
  endtask

  // In-order memory model with configurable latency; reset drops everything in flight.
  task automatic memModel();
    if (!rst_n) begin
      resp_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pend2       = 1'b0;
      pend2_addr  = 32'h0;
      rvalid2     = 1'b0;
      rdata2      = 32'h0;
      return;
    end
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(resp_q[0].addr);
      void'(resp_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEADBEEF;
    end
    if (imem_req && imem_gnt) resp_q.push_back('{addr: imem_addr, due: cyc + lat});
    rvalid2    = pend2;
    rdata2     = memfn(pend2_addr);
    pend2      = req2;
    pend2_addr = addr2;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, v.exp_req});
    if (v.exp_req) checkVal({tag, " imem_addr"}, imem_addr, v.exp_addr);
    checkVal({tag, " ir_valid"}, {31'b0, ir_valid}, {31'b0, v.exp_valid});
    if (v.exp_valid) begin
      checkVal({tag, " ir_pc"}, ir_pc, v.exp_pc);
      checkVal({tag, " ir_data"}, ir_data, memfn(v.exp_pc));
      checkVal({tag, " ir_pc4"}, ir_pc4, v.exp_pc + 32'd4);
`ifdef IFQ_PREDECODE_EN
      checkVal({tag, " ir_is_cti"}, {31'b0, ir_is_cti}, {31'b0, v.exp_cti});
`endif
    end else if (!v.rst_n) begin
      checkVal({tag, " ir_pc rst"}, ir_pc, 32'h0);
      checkVal({tag, " ir_data rst"}, ir_data, 32'h0);
      checkVal({tag, " ir_pc4 rst"}, ir_pc4, 32'h0);
`ifdef IFQ_PREDECODE_EN
      checkVal({tag, " ir_is_cti rst"}, {31'b0, ir_is_cti}, 32'h0);
`endif
    end
  endtask

  task automatic stepBegin(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #2;
    memModel();
    #1;
    checkOutput(v, tag);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    stepBegin(v, tag);
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;  imem_gnt = 1'b0;  ir_ready = 1'b0;
    redirect_valid = 1'b0;  redirect_pc = 32'h0;
    imem_rvalid = 1'b0;  imem_rdata = 32'h0;
    rvalid2 = 1'b0;  rdata2 = 32'h0;  pend2 = 1'b0;  pend2_addr = 32'h0;
`ifndef IFQ_PREDECODE_EN
    ir_is_cti = 1'b0;
    cti2      = 1'b0;
`endif

    // Streaming with 1-cycle memory, then a one-cycle mid-stream reset.
    vecs.push_back(mkv(0,1,1, 0,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(0,1,1, 0,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h4,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h8,  1,32'h0,1));
    vecs.push_back(mkv(1,1,1, 1,32'hC,  1,32'h4,1));
    vecs.push_back(mkv(1,1,1, 1,32'h10, 1,32'h8,0));
    vecs.push_back(mkv(1,1,1, 1,32'h14, 1,32'hC,0));
    vecs.push_back(mkv(0,1,1, 0,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h4,  0,32'h0,0));
    vecs.push_back(mkv(1,1,1, 1,32'h8,  1,32'h0,1));
    // Decode stalled for 10 cycles: credit caps requests at 4, then ordered drain.
    vecs.push_back(mkv(0,1,0, 0,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,0, 1,32'h0,  0,32'h0,0));
    vecs.push_back(mkv(1,1,0, 1,32'h4,  0,32'h0,0));
    vecs.push_back(mkv(1,1,0, 1,32'h8,  1,32'h0,1));
    vecs.push_back(mkv(1,1,0, 1,32'hC,  1,32'h0,1));
    for (int k = 0; k < 6; k++) vecs.push_back(mkv(1,1,0, 0,32'h0, 1,32'h0,1));
    vecs.push_back(mkv(1,1,1, 0,32'h0,  1,32'h0,1));
    vecs.push_back(mkv(1,1,1, 1,32'h10, 1,32'h4,1));
    vecs.push_back(mkv(1,1,1, 1,32'h14, 1,32'h8,0));
    vecs.push_back(mkv(1,1,1, 1,32'h18, 1,32'hC,0));

    $display("[TB] table of %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // 3-cycle memory: redirect to 0x40 while responses are in flight.
    lat = 3;
    runVec(mkv(0,1,0, 0,32'h0,  0,32'h0,0), "flush rst");
    runVec(mkv(1,1,0, 1,32'h0,  0,32'h0,0), "flush c0");
    runVec(mkv(1,1,0, 1,32'h4,  0,32'h0,0), "flush c1");
    runVec(mkv(1,1,0, 1,32'h8,  0,32'h0,0), "flush c2");
    runVec(mkv(1,1,0, 1,32'hC,  0,32'h0,0), "flush c3");
    runVec(withRedirect(mkv(1,1,0, 0,32'h0, 1,32'h0,1), 32'h40), "flush redir");
    runVec(mkv(1,1,1, 0,32'h0,  0,32'h0,0), "flush drop1");
    runVec(mkv(1,1,1, 0,32'h0,  0,32'h0,0), "flush drop2");
    runVec(mkv(1,1,1, 1,32'h40, 0,32'h0,0), "flush c7");
    runVec(mkv(1,1,1, 1,32'h44, 0,32'h0,0), "flush c8");
    runVec(mkv(1,1,1, 1,32'h48, 0,32'h0,0), "flush c9");
    runVec(mkv(1,1,1, 1,32'h4C, 0,32'h0,0), "flush c10");
    runVec(mkv(1,1,1, 0,32'h0,  1,32'h40,0), "flush c11");
    runVec(mkv(1,1,1, 1,32'h50, 1,32'h44,0), "flush c12");

    // Unaligned redirect coinciding with a response and a pop.
    lat = 1;
    runVec(mkv(0,1,1, 0,32'h0,   0,32'h0,0), "unal rst");
    runVec(mkv(1,1,1, 1,32'h0,   0,32'h0,0), "unal c0");
    runVec(mkv(1,1,1, 1,32'h4,   0,32'h0,0), "unal c1");
    runVec(withRedirect(mkv(1,1,1, 0,32'h0, 1,32'h0,1), 32'h103), "unal redir");
    runVec(mkv(1,1,1, 1,32'h100, 0,32'h0,0), "unal c3");
    runVec(mkv(1,1,1, 1,32'h104, 0,32'h0,0), "unal c4");
    runVec(mkv(1,1,1, 1,32'h108, 1,32'h100,0), "unal c5");

    // Fetch PC wrap on the RESET_PC=32'hFFFFFFFC instance.
    runVec(mkv(0,1,1, 0,32'h0, 0,32'h0,0), "wrap rst");
    stepBegin(mkv(1,1,1, 1,32'h0, 0,32'h0,0), "wrap c0");
    checkVal("wrap req c0", {31'b0, req2}, 32'h1);
    checkVal("wrap addr c0", addr2, 32'hFFFFFFFC);
    checkVal("wrap valid c0", {31'b0, valid2}, 32'h0);
    @(posedge clk);
    stepBegin(mkv(1,1,1, 1,32'h4, 0,32'h0,0), "wrap c1");
    checkVal("wrap req c1", {31'b0, req2}, 32'h1);
    checkVal("wrap addr c1", addr2, 32'h0);
    @(posedge clk);
    stepBegin(mkv(1,1,1, 1,32'h8, 1,32'h0,1), "wrap c2");
    checkVal("wrap valid c2", {31'b0, valid2}, 32'h1);
    checkVal("wrap pc c2", pc2, 32'hFFFFFFFC);
    checkVal("wrap pc4 c2", pc4_2, 32'h0);
    checkVal("wrap data c2", data2, memfn(32'hFFFFFFFC));
`ifdef IFQ_PREDECODE_EN
    checkVal("wrap cti c2", {31'b0, cti2}, 32'h0);
`endif
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
